// File: rtl/rd_return_collector.sv
// rd_return_collector
//   Per-core receiver on the memory mux read-return path. Words whose
//   destination matches CORE_ID are gathered into a cache line. Each
//   finished line is pushed into a 2-entry queue. The head of that queue
//   is offered to the cache fill logic over a valid/ready handshake.
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous reset, active low
//   RDreturn       returned data word
//   RDdest         destination core of RDreturn (0 = idle slot)
//   lineData       head line of the queue, word k in bits [32k+31:32k]
//   lineValid      queue non-empty
//   lineReady      consumer accepts head line (pop on lineValid & lineReady)
//   pending        a line is partially assembled
//   wcnt           words captured into the current line
//   overflow       sticky: a completed line was dropped on a full queue
//   clearOverflow  clears overflow (a same-cycle drop wins)
module rd_return_collector #(
    parameter logic [3:0] CORE_ID        = 4'd1,
    parameter int         WORDS_PER_LINE = 8,
    parameter int         WCNT_W         = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  RDreturn,
    input  logic [3:0]                   RDdest,
    output logic [32*WORDS_PER_LINE-1:0] lineData,
    output logic                         lineValid,
    input  logic                         lineReady,
    output logic                         pending,
    output logic [WCNT_W-1:0]            wcnt,
    output logic                         overflow,
    input  logic                         clearOverflow
);

    localparam int LINE_W = 32 * WORDS_PER_LINE;

    logic [31:0]       asm_word [WORDS_PER_LINE];
    logic [LINE_W-1:0] line_done;
    logic [LINE_W-1:0] head_q;
    logic [LINE_W-1:0] tail_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic [1:0]        count_q;
    logic [1:0]        count_nxt;
    logic              overflow_q;

    logic hit;
    logic push;
    logic pop;
    logic drop;
    logic head_load_line;
    logic head_load_tail;
    logic tail_load;

    // A word arriving while reset is asserted is ignored, so hit is gated.
    assign hit  = reset && (RDdest == CORE_ID);
    assign push = hit && (wcnt_q == WCNT_W'(WORDS_PER_LINE - 1));
    assign pop  = lineValid && lineReady;
    assign drop = push && (count_q == 2'd2) && !pop;

    // The completing word goes straight into the pushed line, not through
    // the assembly register, so a new line can start on the next cycle.
    always_comb begin
        line_done = '0;
        for (int k = 0; k < WORDS_PER_LINE - 1; k++) begin
            line_done[32*k +: 32] = asm_word[k];
        end
        line_done[32*(WORDS_PER_LINE-1) +: 32] = RDreturn;
    end

    // Queue update: head/tail registers with an occupancy count.
    always_comb begin
        head_load_line = 1'b0;
        head_load_tail = 1'b0;
        tail_load      = 1'b0;
        count_nxt      = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_load_line = 1'b1;
                    count_nxt      = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_load_line = 1'b1;
                end else if (push) begin
                    tail_load = 1'b1;
                    count_nxt = 2'd2;
                end else if (pop) begin
                    count_nxt = 2'd0;
                end
            end
            default: begin
                // Full: a push is only accepted when the head leaves.
                if (pop) begin
                    head_load_tail = 1'b1;
                    if (push) begin
                        tail_load = 1'b1;
                    end else begin
                        count_nxt = 2'd1;
                    end
                end
            end
        endcase
    end

    // Control state
    always_ff @(posedge clock) begin
        if (!reset) begin
            wcnt_q     <= '0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (hit) begin
                wcnt_q <= wcnt_q + 1'b1;
            end
            count_q <= count_nxt;
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clearOverflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Data state (not reset; lineData is masked while the queue is empty)
    always_ff @(posedge clock) begin
        if (hit) begin
            asm_word[wcnt_q] <= RDreturn;
        end
        if (head_load_line) begin
            head_q <= line_done;
        end else if (head_load_tail) begin
            head_q <= tail_q;
        end
        if (tail_load) begin
            tail_q <= line_done;
        end
    end

    assign lineValid = (count_q != 2'd0);
    assign lineData  = lineValid ? head_q : '0;
    assign pending   = (wcnt_q != '0);
    assign wcnt      = wcnt_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_rd_return_collector.sv
module tb_rd_return_collector;

    localparam logic [3:0] CORE_ID = 4'd1;
    localparam int         WPL     = 8;
    localparam int         WW      = 3;
    localparam int         LW      = 32 * WPL;

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   RDreturn;
    logic [3:0]    RDdest;
    logic [LW-1:0] lineData;
    logic          lineValid;
    logic          lineReady;
    logic          pending;
    logic [WW-1:0] wcnt;
    logic          overflow;
    logic          clearOverflow;

    int n_checks = 0;
    int n_fail   = 0;

    rd_return_collector #(
        .CORE_ID(CORE_ID),
        .WORDS_PER_LINE(WPL),
        .WCNT_W(WW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .RDreturn(RDreturn),
        .RDdest(RDdest),
        .lineData(lineData),
        .lineValid(lineValid),
        .lineReady(lineReady),
        .pending(pending),
        .wcnt(wcnt),
        .overflow(overflow),
        .clearOverflow(clearOverflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line whose word k is base+k.
    function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < WPL; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d);
        RDdest   = CORE_ID;
        RDreturn = d;
        step();
        RDdest   = 4'd0;
        RDreturn = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL reset_lineValid got %b want 0", lineValid); end
        n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
        n_checks++; if (wcnt !== 3'd0) begin n_fail++; $display("FAIL reset_wcnt got %0d want 0", wcnt); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_checks++; if (lineData !== '0) begin n_fail++; $display("FAIL reset_lineData got %h want 0", lineData); end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_line();
        send_word(32'h11);
        send_word(32'h22);
        send_word(32'h33);
        n_checks++; if (wcnt !== 3'd3) begin n_fail++; $display("FAIL midline_wcnt got %0d want 3", wcnt); end
        n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL midline_pending got %b want 1", pending); end
        // Reset with a hit on the same edge: the word must be ignored.
        reset = 1'b0;
        send_word(32'h44);
        reset = 1'b1;
        n_checks++; if (wcnt !== 3'd0) begin n_fail++; $display("FAIL midline_wcnt_after_reset got %0d want 0", wcnt); end
        for (int i = 0; i < 8; i++) send_word(32'hA0 + 32'(i));
        n_checks++; if (lineValid !== 1'b1) begin n_fail++; $display("FAIL midline_lineValid got %b want 1", lineValid); end
        n_checks++; if (lineData !== mk_line(32'hA0)) begin n_fail++; $display("FAIL midline_lineData got %h want %h", lineData, mk_line(32'hA0)); end
        n_checks++; if (wcnt !== 3'd0) begin n_fail++; $display("FAIL midline_wcnt_end got %0d want 0", wcnt); end
        lineReady = 1'b1;
        step();
        lineReady = 1'b0;
        n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL midline_drain got %b want 0", lineValid); end
    endtask

    task automatic test_filtering();
        lineReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            RDdest = 4'd0; RDreturn = 32'hBAD0_0000 + 32'(i);
            step();
            RDdest = CORE_ID + 4'd1; RDreturn = 32'hBAD1_0000 + 32'(i);
            step();
            n_checks++; if (wcnt !== 3'(i)) begin n_fail++; $display("FAIL filter_wcnt_idle%0d got %0d want %0d", i, wcnt, i); end
            send_word(32'h100 + 32'(i));
            if (i < 7) begin
                n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL filter_pending%0d got %b want 1", i, pending); end
                n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL filter_early_valid%0d got %b want 0", i, lineValid); end
            end
        end
        n_checks++; if (lineValid !== 1'b1) begin n_fail++; $display("FAIL filter_lineValid got %b want 1", lineValid); end
        n_checks++; if (lineData !== mk_line(32'h100)) begin n_fail++; $display("FAIL filter_lineData got %h want %h", lineData, mk_line(32'h100)); end
        n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL filter_pending_end got %b want 0", pending); end
        step();
        n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL filter_one_cycle got %b want 0", lineValid); end
        lineReady = 1'b0;
    endtask

    task automatic test_back_to_back();
        lineReady = 1'b0;
        for (int i = 0; i < 16; i++) send_word(32'(i));
        n_checks++; if (lineValid !== 1'b1) begin n_fail++; $display("FAIL b2b_lineValid got %b want 1", lineValid); end
        n_checks++; if (lineData !== mk_line(32'd0)) begin n_fail++; $display("FAIL b2b_head0 got %h want %h", lineData, mk_line(32'd0)); end
        lineReady = 1'b1;
        step();
        n_checks++; if (lineValid !== 1'b1) begin n_fail++; $display("FAIL b2b_no_bubble got %b want 1", lineValid); end
        n_checks++; if (lineData !== mk_line(32'd8)) begin n_fail++; $display("FAIL b2b_head1 got %h want %h", lineData, mk_line(32'd8)); end
        step();
        lineReady = 1'b0;
        n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", lineValid); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_overflow got %b want 0", overflow); end
    endtask

    task automatic test_overflow();
        lineReady = 1'b0;
        for (int i = 0; i < 24; i++) send_word(32'(i));
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
        n_checks++; if (lineData !== mk_line(32'd0)) begin n_fail++; $display("FAIL ovf_head0 got %h want %h", lineData, mk_line(32'd0)); end
        lineReady = 1'b1;
        step();
        n_checks++; if (lineData !== mk_line(32'd8)) begin n_fail++; $display("FAIL ovf_head1 got %h want %h", lineData, mk_line(32'd8)); end
        step();
        lineReady = 1'b0;
        n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained got %b want 0", lineValid); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        clearOverflow = 1'b1;
        step();
        clearOverflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        lineReady = 1'b0;
        for (int i = 0; i < 23; i++) send_word(32'h200 + 32'(i));
        n_checks++; if (lineData !== mk_line(32'h200)) begin n_fail++; $display("FAIL pp_head0 got %h want %h", lineData, mk_line(32'h200)); end
        lineReady = 1'b1;
        send_word(32'h217);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow got %b want 0", overflow); end
        n_checks++; if (lineData !== mk_line(32'h208)) begin n_fail++; $display("FAIL pp_head1 got %h want %h", lineData, mk_line(32'h208)); end
        step();
        n_checks++; if (lineData !== mk_line(32'h210)) begin n_fail++; $display("FAIL pp_head2 got %h want %h", lineData, mk_line(32'h210)); end
        step();
        lineReady = 1'b0;
        n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL pp_drained got %b want 0", lineValid); end
    endtask

    task automatic test_set_wins();
        lineReady = 1'b0;
        for (int i = 0; i < 23; i++) send_word(32'h300 + 32'(i));
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sw_pre got %b want 0", overflow); end
        clearOverflow = 1'b1;
        send_word(32'h317);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sw_set_wins got %b want 1", overflow); end
        step();
        clearOverflow = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sw_clear got %b want 0", overflow); end
        lineReady = 1'b1;
        step();
        n_checks++; if (lineData !== mk_line(32'h308)) begin n_fail++; $display("FAIL sw_head1 got %h want %h", lineData, mk_line(32'h308)); end
        step();
        lineReady = 1'b0;
        n_checks++; if (lineValid !== 1'b0) begin n_fail++; $display("FAIL sw_drained got %b want 0", lineValid); end
    endtask

    initial begin
        reset         = 1'b0;
        RDreturn      = 32'h0;
        RDdest        = 4'd0;
        lineReady     = 1'b0;
        clearOverflow = 1'b0;
        test_reset();
        test_reset_mid_line();
        test_filtering();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_set_wins();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
